// File: rtl/memprep_pkg.sv
// Shared types and helpers for the MEMPREP stage: FSM states, load/store size
// encodings and the alignment rule.
package memprep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Halfwords need an even address and words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (funct3)
            LSU_H, LSU_HU: mis = off[0];
            LSU_W:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memprep_stage_lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, plus
// extraction and sign/zero extension of the load response word.
module lsu_align
    import memprep_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic signed [7:0]  load_byte;
    logic signed [15:0] load_half;

    // Move the addressed byte/half down to lane 0 before extending.
    assign shifted   = rdata >> {off, 3'b000};
    assign load_byte = shifted[7:0];
    assign load_half = shifted[15:0];

    always_comb begin
        be    = 4'hF;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            LSU_B:   load_data = 32'($signed(load_byte));
            LSU_H:   load_data = 32'($signed(load_half));
            LSU_BU:  load_data = {24'd0, shifted[7:0]};
            LSU_HU:  load_data = {16'd0, shifted[15:0]};
            LSU_W:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memprep_stage.sv
// MEMPREP stage: drives the data-memory request/response bus, stalls upstream
// while a transaction is outstanding and registers results towards WB.
module memprep_stage
    import memprep_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              invalid_MEMPREP,
    input  logic [31:0]       pc4_MEMPREP,
    input  logic [3:0]        rd_MEMPREP,
    input  logic [31:0]       alu_result_MEMPREP,
    input  logic              regfile_we_MEMPREP,
    input  logic [1:0]        rd_data_sel_MEMPREP,
    input  logic              mem_read_MEMPREP,
    input  logic              mem_write_MEMPREP,
    input  logic [2:0]        funct3_MEMPREP,
    input  logic [31:0]       store_data_MEMPREP,
    output logic              stall_MEMPREP,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              invalid_WB,
    output logic [31:0]       pc4_WB,
    output logic [3:0]        rd_WB,
    output logic [31:0]       alu_result_WB,
    output logic              regfile_we_WB,
    output logic [1:0]        rd_data_sel_WB,
    output logic [31:0]       load_data_WB,
    output logic              misaligned_WB
);

    state_t      state;
    logic [1:0]  off;
    logic        mem_op;
    logic        misaligned;
    logic        valid_op;
    logic        is_store;
    logic        accept;
    logic        complete;
    logic [31:0] load_data;

    assign off        = alu_result_MEMPREP[1:0];
    assign mem_op     = !invalid_MEMPREP && (mem_read_MEMPREP || mem_write_MEMPREP);
    assign misaligned = mem_op && is_misaligned(funct3_MEMPREP, off);
    assign valid_op   = mem_op && !misaligned;
    // A write flag always wins, so read+write together behaves as a store.
    assign is_store   = mem_write_MEMPREP;

    lsu_align u_align (
        .funct3     (funct3_MEMPREP),
        .off        (off),
        .store_data (store_data_MEMPREP),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    // Upstream is frozen while stalled, so the request fields stay stable in REQ.
    assign dmem_addr      = {alu_result_MEMPREP[ADDR_W-1:2], 2'b00};
    assign dmem_we        = is_store;
    assign dmem_req_valid = (state == REQ) || ((state == IDLE) && valid_op && !rst);
    assign accept         = dmem_req_valid && dmem_req_ready;

    always_comb begin
        complete = 1'b1;
        case (state)
            IDLE:    complete = !valid_op || (is_store && accept);
            REQ:     complete = is_store && accept;
            RESP:    complete = dmem_rvalid;
            default: complete = 1'b1;
        endcase
    end

    assign stall_MEMPREP = !rst && !complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_op) begin
                        if (!dmem_req_ready) state <= REQ;
                        else if (!is_store)  state <= RESP;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) state <= is_store ? IDLE : RESP;
                end
                RESP: begin
                    if (dmem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // WB register: a bubble while stalled, the full instruction on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_WB     <= 1'b1;
            pc4_WB         <= '0;
            rd_WB          <= '0;
            alu_result_WB  <= '0;
            regfile_we_WB  <= 1'b0;
            rd_data_sel_WB <= '0;
            load_data_WB   <= '0;
            misaligned_WB  <= 1'b0;
        end else if (stall_MEMPREP) begin
            invalid_WB     <= 1'b1;
            regfile_we_WB  <= 1'b0;
            misaligned_WB  <= 1'b0;
        end else begin
            invalid_WB     <= invalid_MEMPREP;
            pc4_WB         <= pc4_MEMPREP;
            rd_WB          <= rd_MEMPREP;
            alu_result_WB  <= alu_result_MEMPREP;
            regfile_we_WB  <= regfile_we_MEMPREP && !invalid_MEMPREP && !misaligned;
            rd_data_sel_WB <= rd_data_sel_MEMPREP;
            load_data_WB   <= (state == RESP) ? load_data : 32'd0;
            misaligned_WB  <= misaligned;
        end
    end

endmodule

// File: doc/memprep_stage.md
Name: memprep_stage

Overview:
- MEMPREP stage of the RV32E pipeline, downstream of the EX→MEMPREP pipeline register, upstream of writeback.
- Performs data-memory access over a valid/ready request plus response-valid bus.
- Aligns store data, generates byte enables, sign/zero-extends loads and detects misalignment.
- Stalls upstream while a transaction is outstanding; forwards results to WB through its own output register.

Parameters:
- ADDR_W, 32, data-memory byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- invalid_MEMPREP  in  1  bubble flag from upstream register.
- pc4_MEMPREP  in  32  PC+4 of instruction.
- rd_MEMPREP  in  4  destination register.
- alu_result_MEMPREP  in  32  ALU result; memory byte address for mem ops.
- regfile_we_MEMPREP  in  1  register-file write enable.
- rd_data_sel_MEMPREP  in  2  WB mux select.
- mem_read_MEMPREP  in  1  instruction is a load.
- mem_write_MEMPREP  in  1  instruction is a store.
- funct3_MEMPREP  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- store_data_MEMPREP  in  32  rs2 value.
- stall_MEMPREP  out  1  hold upstream register and all earlier stages.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  request accepted.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- dmem_we  out  1  1 = store.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  32  load response word.
- invalid_WB, pc4_WB, rd_WB, alu_result_WB, regfile_we_WB, rd_data_sel_WB  out  1/32/4/32/1/2  registered pass-through.
- load_data_WB  out  32  aligned, extended load result.
- misaligned_WB  out  1  access misaligned; no bus transaction was made.

Behaviour:
- Reset: state IDLE. All *_WB outputs 0 except invalid_WB=1. dmem_req_valid=0. stall_MEMPREP=0.
- FSM states:
  - IDLE → REQ: valid mem op and ready=0.
  - IDLE → RESP: load and ready=1.
  - REQ → RESP: load and ready=1.
  - REQ → IDLE: store and ready=1.
  - RESP → IDLE: rvalid=1.
- Valid mem op: invalid=0, (mem_read|mem_write)=1, not misaligned.
- In IDLE, dmem_req_valid is combinational from the input for a valid mem op (same cycle). Held in REQ with addr/we/be/wdata stable until ready.
- Store with ready=1 in IDLE: no stall.
- Store with ready=0: stall every cycle until the ready cycle.
- Load: stall from request cycle through the cycle before rvalid. With ready=1 and rvalid the next cycle, a load costs exactly 1 stall cycle.
- stall_MEMPREP=1 iff the current instruction's transaction does not complete this cycle. Completion means: store accepted, or rvalid seen in RESP.
- While stall=1, the WB register loads a bubble: invalid_WB=1, regfile_we_WB=0, misaligned_WB=0.
- On completion, or for any non-mem/invalid instruction, WB registers all fields on the next edge. Latency is 1 cycle.
- invalid_MEMPREP=1 forces regfile_we_WB=0 and suppresses all bus activity.
- Misalignment:
  - H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - No request is issued and there is no stall.
  - misaligned_WB=1 and regfile_we_WB=0.
- Store lanes:
  - SB: be=1<<off, wdata=byte replicated ×4.
  - SH: be=2'b11<<off, wdata=half replicated ×2.
  - SW: be=4'hF.
  - off = addr[1:0].
- Load extraction:
  - Byte/half selected by off from rdata.
  - Sign-extended for 000/001, zero-extended for 100/101.
  - 010 passes the word through.
- dmem_rvalid is ignored outside RESP. dmem_req_ready is ignored when req_valid=0.
- rst mid-transaction: next state IDLE, req_valid drops on the next cycle, and a late rvalid is discarded.
- Both mem_read and mem_write set: treated as store.

Decomposition:
- Package memprep_pkg holds:
  - state enum (IDLE, REQ, RESP);
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - function is_misaligned(funct3, off).
- One combinational sub-module, lsu_align. It takes funct3, off, store_data and rdata, and produces be, wdata and load_data.
- memprep_stage holds the FSM, the stall logic and the WB register.

Test Plan:
- Reset with rst=1 for 2 cycles → invalid_WB=1, regfile_we_WB=0, dmem_req_valid=0, stall=0.
- SB at addr 0x1003 with data 0x000000A5, ready=1 → same cycle: dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, stall=0.
- LB at addr 0x2001, ready=1, rvalid next cycle with rdata=0x0000_80FF → stall=1 for 1 cycle, then load_data_WB=0xFFFFFF80. LBU on the same data → 0x00000080.
- LW with ready=0 for 3 cycles, then ready=1, rvalid 2 cycles later → stall held for 5 cycles, dmem_addr stable throughout, 5 bubbles into WB.
- LH at addr 0x3001 → no request, no stall, misaligned_WB=1, regfile_we_WB=0 on the next cycle.
- Load in RESP, assert rst, then rvalid → state IDLE, rvalid ignored, WB is a bubble, stall=0.
